// File: rtl/l1i_nextline_prefetcher.sv
// Next-line L1I prefetcher: turns demand misses into same-page next-line L2 fetches and L1I fills.
// Optional PF_STATS_EN macro adds saturating issue/drop/trigger counters.
module l1i_nextline_prefetcher #(
    parameter int DEGREE         = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int FILTER_ENTRIES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         miss_valid,
    input  logic [31:0]  miss_paddr,
    input  logic         demand_busy,
    output logic [31:0]  pf_l2_addr,
    output logic         pf_l2_request,
    input  logic [255:0] pf_l2_data,
    input  logic         pf_l2_done,
    output logic [31:0]  prefetch_addr,
    output logic [255:0] prefetch_data,
    output logic         prefetch_valid
`ifdef PF_STATS_EN
    ,
    output logic [31:0]  stat_issued,
    output logic [31:0]  stat_dropped,
    output logic [31:0]  stat_triggers
`endif
);

    localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int FW = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;
    localparam int KW = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    logic [26:0]   fifo_mem_q [QUEUE_DEPTH];
    logic [QW-1:0] rd_ptr_q, wr_ptr_q;
    logic [QW:0]   count_q;

    logic [26:0]               filt_addr_q [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] filt_valid_q;
    logic [FW-1:0]             filt_ptr_q;

    logic          gen_active_q;
    logic [26:0]   base_q;
    logic [19:0]   page_q;
    logic [KW-1:0] k_q;

    logic [1:0]   state_q;
    logic         req_q, pv_q;
    logic [31:0]  addr_q, pa_q;
    logic [255:0] pd_q;

    logic [26:0]               miss_line, head, cand, filt_ins_addr;
    logic [27:0]               cand_sum;
    logic [FILTER_ENTRIES-1:0] filt_hit_v, trig_hit_v;
    logic [QUEUE_DEPTH-1:0]    fifo_hit_v;
    logic fifo_empty, fifo_full, do_pop, page_ok, inflight_hit, dup;
    logic gen_step, full_drop, gen_stop, cand_push, filt_ins;
    logic unused_low_bits;

    assign unused_low_bits = ^miss_paddr[4:0];
    assign miss_line  = miss_paddr[31:5];
    assign head       = fifo_mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (QW+1)'(QUEUE_DEPTH));

    // A trigger flushes the FIFO, so no pop is allowed in the same cycle.
    assign do_pop = (state_q == ST_IDLE) && !fifo_empty && !demand_busy && !miss_valid;

    assign cand_sum = {1'b0, base_q} + {25'd0, k_q};
    assign cand     = cand_sum[26:0];
    assign page_ok  = !cand_sum[27] && (cand[26:7] == page_q);

    genvar gi;
    generate
        for (gi = 0; gi < FILTER_ENTRIES; gi++) begin : g_filt
            assign filt_hit_v[gi] = filt_valid_q[gi] && (filt_addr_q[gi] == cand);
            assign trig_hit_v[gi] = filt_valid_q[gi] && (filt_addr_q[gi] == miss_line);
        end
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_fifo
            logic [QW-1:0] off;
            assign off            = QW'(gi) - rd_ptr_q;
            assign fifo_hit_v[gi] = ({1'b0, off} < count_q) && (fifo_mem_q[gi] == cand);
        end
    endgenerate

    assign inflight_hit = (state_q != ST_IDLE) && (addr_q[31:5] == cand);
    assign dup          = (|filt_hit_v) || (|fifo_hit_v) || inflight_hit;

    assign gen_step  = gen_active_q && !miss_valid;
    assign full_drop = page_ok && !dup && fifo_full && !do_pop;
    assign gen_stop  = !page_ok || full_drop || (k_q == KW'(DEGREE));
    assign cand_push = gen_step && page_ok && !dup && (!fifo_full || do_pop);

    // Trigger line is recorded once; issued lines always enter the filter.
    assign filt_ins      = (miss_valid && !(|trig_hit_v)) || do_pop;
    assign filt_ins_addr = miss_valid ? miss_line : head;

    always_ff @(posedge clk) begin
        if (cand_push) fifo_mem_q[wr_ptr_q] <= cand;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FILTER_ENTRIES; i++) filt_addr_q[i] <= '0;
            filt_valid_q <= '0;
            filt_ptr_q   <= '0;
            gen_active_q <= 1'b0;
            base_q       <= '0;
            page_q       <= '0;
            k_q          <= '0;
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            pv_q         <= 1'b0;
            addr_q       <= '0;
            pa_q         <= '0;
            pd_q         <= '0;
        end else begin
            if (miss_valid) begin
                base_q       <= miss_line;
                page_q       <= miss_paddr[31:12];
                k_q          <= KW'(1);
                gen_active_q <= 1'b1;
            end else if (gen_step) begin
                k_q <= k_q + KW'(1);
                if (gen_stop) gen_active_q <= 1'b0;
            end

            if (miss_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_pop)    rd_ptr_q <= rd_ptr_q + QW'(1);
                if (cand_push) wr_ptr_q <= wr_ptr_q + QW'(1);
                count_q <= count_q + {{QW{1'b0}}, cand_push} - {{QW{1'b0}}, do_pop};
            end

            if (filt_ins) begin
                filt_addr_q[filt_ptr_q]  <= filt_ins_addr;
                filt_valid_q[filt_ptr_q] <= 1'b1;
                filt_ptr_q <= (filt_ptr_q == FW'(FILTER_ENTRIES - 1)) ? '0 : filt_ptr_q + FW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (do_pop) begin
                        addr_q  <= {head, 5'b0};
                        req_q   <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pf_l2_done) begin
                        req_q   <= 1'b0;
                        pd_q    <= pf_l2_data;
                        pa_q    <= addr_q;
                        pv_q    <= 1'b1;
                        state_q <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    pv_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pf_l2_addr     = addr_q;
    assign pf_l2_request  = req_q;
    assign prefetch_addr  = pa_q;
    assign prefetch_data  = pd_q;
    assign prefetch_valid = pv_q;

`ifdef PF_STATS_EN
    logic [KW-1:0] drop_n;
    logic [32:0]   drop_sum;
    logic [31:0]   issued_q, dropped_q, triggers_q;

    // Page-limit and full-FIFO stops discard every remaining candidate of the trigger.
    always_comb begin
        drop_n = '0;
        if (gen_step) begin
            if (!page_ok || full_drop) drop_n = KW'(DEGREE) - k_q + KW'(1);
            else if (dup)              drop_n = KW'(1);
        end
    end
    assign drop_sum = {1'b0, dropped_q} + {30'd0, drop_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q   <= '0;
            dropped_q  <= '0;
            triggers_q <= '0;
        end else begin
            if (do_pop && issued_q != '1)       issued_q   <= issued_q + 32'd1;
            if (miss_valid && triggers_q != '1) triggers_q <= triggers_q + 32'd1;
            dropped_q <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign stat_issued   = issued_q;
    assign stat_dropped  = dropped_q;
    assign stat_triggers = triggers_q;
`endif

endmodule

// File: tb/tb_l1i_nextline_prefetcher.sv
// Scoreboard bench for l1i_nextline_prefetcher: expected L2 requests and L1I fills are queued
// when misses are driven and compared as the DUT produces them.
module tb_l1i_nextline_prefetcher;

    localparam int L2_LAT = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         miss_valid;
    logic [31:0]  miss_paddr;
    logic         demand_busy;
    logic [31:0]  pf_l2_addr;
    logic         pf_l2_request;
    logic [255:0] pf_l2_data;
    logic         pf_l2_done;
    logic [31:0]  prefetch_addr;
    logic [255:0] prefetch_data;
    logic         prefetch_valid;

    always #5 clk = ~clk;

    l1i_nextline_prefetcher #(.DEGREE(2), .QUEUE_DEPTH(4), .FILTER_ENTRIES(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .miss_valid     (miss_valid),
        .miss_paddr     (miss_paddr),
        .demand_busy    (demand_busy),
        .pf_l2_addr     (pf_l2_addr),
        .pf_l2_request  (pf_l2_request),
        .pf_l2_data     (pf_l2_data),
        .pf_l2_done     (pf_l2_done),
        .prefetch_addr  (prefetch_addr),
        .prefetch_data  (prefetch_data),
        .prefetch_valid (prefetch_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  exp_req_q [$];
    logic [287:0] exp_pf_q  [$];

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = (a * (i + 3)) ^ 32'h5A5A_0000;
        return d;
    endfunction

    // Monitor plus L2 responder; each completes L2_LAT negedges after the request rises.
    initial begin
        logic         prev_req;
        logic         prev_valid;
        int           l2_cnt;
        logic [287:0] e;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        l2_cnt     = 0;
        pf_l2_done = 1'b0;
        pf_l2_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
                l2_cnt     = 0;
                pf_l2_done = 1'b0;
            end else begin
                if (pf_l2_request && !prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        check_eq("unexpected_req", {255'd0, pf_l2_request}, 256'd0);
                    end else begin
                        check_eq("req_addr", pf_l2_addr, exp_req_q.pop_front());
                        $display("request 0x%08h", pf_l2_addr);
                    end
                end
                if (prefetch_valid) begin
                    check_eq("pf_pulse_width", {255'd0, prev_valid}, 256'd0);
                    if (exp_pf_q.size() == 0) begin
                        check_eq("unexpected_pf", {255'd0, prefetch_valid}, 256'd0);
                    end else begin
                        e = exp_pf_q.pop_front();
                        check_eq("pf_addr", prefetch_addr, e[287:256]);
                        check_eq("pf_data", prefetch_data, e[255:0]);
                        $display("fill    0x%08h", prefetch_addr);
                    end
                end
                prev_req   = pf_l2_request;
                prev_valid = prefetch_valid;
                if (pf_l2_done) begin
                    pf_l2_done = 1'b0;
                end else if (pf_l2_request) begin
                    l2_cnt++;
                    if (l2_cnt == L2_LAT) begin
                        l2_cnt     = 0;
                        pf_l2_data = line_data(pf_l2_addr);
                        pf_l2_done = 1'b1;
                        exp_pf_q.push_back({pf_l2_addr, pf_l2_data});
                    end
                end
            end
        end
    end

    task automatic pulse_miss(input logic [31:0] a);
        @(posedge clk); #1;
        miss_valid = 1'b1;
        miss_paddr = a;
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int i;
        i = 0;
        while ((exp_req_q.size() != 0 || exp_pf_q.size() != 0 || pf_l2_request) && i < max_cycles) begin
            @(posedge clk); #1;
            i++;
        end
        repeat (8) @(posedge clk);
        #1;
        check_eq({tag, "_pending"}, exp_req_q.size() + exp_pf_q.size(), 256'd0);
    endtask

    task automatic wait_request(input string tag, input int max_cycles);
        int i;
        i = 0;
        while (!pf_l2_request && i < max_cycles) begin
            @(posedge clk); #1;
            i++;
        end
        check_eq({tag, "_req_seen"}, {255'd0, pf_l2_request}, 256'd1);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        miss_valid  = 1'b0;
        miss_paddr  = '0;
        demand_busy = 1'b0;
        apply_reset();
        @(negedge clk);
        check_eq("rst_req",      {255'd0, pf_l2_request},  256'd0);
        check_eq("rst_l2_addr",  pf_l2_addr,               256'd0);
        check_eq("rst_pf_valid", {255'd0, prefetch_valid}, 256'd0);
        check_eq("rst_pf_addr",  prefetch_addr,            256'd0);
        check_eq("rst_pf_data",  prefetch_data,            256'd0);

        // Basic two-line stream.
        exp_req_q.push_back(32'h0000_1060);
        exp_req_q.push_back(32'h0000_1080);
        pulse_miss(32'h0000_1040);
        drain("stream_1040", 60);

        // Same miss again: both candidates are in the filter.
        pulse_miss(32'h0000_1040);
        drain("filter_1040", 30);

        // Last line before a page boundary.
        exp_req_q.push_back(32'h0000_1FE0);
        pulse_miss(32'h0000_1FC0);
        drain("page_1fc0", 40);

        // demand_busy blocks issue; request follows one cycle after it falls.
        @(posedge clk); #1;
        demand_busy = 1'b1;
        exp_req_q.push_back(32'h0000_5020);
        exp_req_q.push_back(32'h0000_5040);
        pulse_miss(32'h0000_5000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("busy_block", {255'd0, pf_l2_request}, 256'd0);
        end
        @(posedge clk); #1;
        demand_busy = 1'b0;
        @(negedge clk);
        check_eq("busy_fall_same", {255'd0, pf_l2_request}, 256'd0);
        @(negedge clk);
        check_eq("busy_issue_lat", {255'd0, pf_l2_request}, 256'd1);
        drain("busy_5000", 60);

        // Asynchronous reset while waiting on L2.
        exp_req_q.push_back(32'h0000_1060);
        pulse_miss(32'h0000_1040);
        wait_request("rst_mid", 20);
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_req",   {255'd0, pf_l2_request},  256'd0);
        check_eq("rst_async_addr",  pf_l2_addr,               256'd0);
        check_eq("rst_async_valid", {255'd0, prefetch_valid}, 256'd0);
        exp_req_q.delete();
        exp_pf_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        drain("after_reset", 30);

        // New trigger while 0x1060 is in flight: it completes, the stream restarts at 0x3000.
        exp_req_q.push_back(32'h0000_1060);
        pulse_miss(32'h0000_1040);
        wait_request("retrig", 20);
        exp_req_q.push_back(32'h0000_3020);
        exp_req_q.push_back(32'h0000_3040);
        pulse_miss(32'h0000_3000);
        drain("retrig_3000", 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
